// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock LSB first via a + ~b + 1.
// Latency WIDTH cycles from accepted start to done; start is ignored while busy (no queuing).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             overflow,
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic [CW-1:0]    cnt;
  logic             c, c_nxt, s;
  logic             a_msb, b_msb;
  logic             last_bit;

  // Single full-adder cell on the current LSBs.
  always_comb begin
    s        = a_sr[0] ^ b_sr[0] ^ c;
    c_nxt    = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    r_nxt    = {s, r_sr[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      overflow <= 1'b0;
      borrow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= ~b;
            r_sr  <= '0;
            c     <= 1'b1;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_nxt;
          c    <= c_nxt;
          cnt  <= cnt + CW'(1);
          // The final bit is still in flight at this edge, so load from the next-state values.
          if (last_bit) begin
            diff     <= r_nxt;
            borrow   <= ~c_nxt;
            overflow <= (a_msb != b_msb) && (s != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] diff;
  logic       overflow, borrow;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int both_hi  = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .overflow (overflow),
    .borrow   (borrow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && done) both_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge; returns 1ns after the accepting edge.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // elapsed = edges already passed since the accepting edge.
  task automatic finish_op(input string tag, input int elapsed, input logic [7:0] ed,
                           input logic eov, input logic ebo);
    int n;
    n = elapsed;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_ovf"}, overflow, eov);
    chk({tag, "_brw"}, borrow, ebo);
    chk({tag, "_busy_at_done"}, busy, 0);
    tick();
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int dc0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_flags", {overflow, borrow}, 2'b00);
    rst_n = 1'b1;
    tick();

    launch(8'h36, 8'h22);
    chk("t1_busy_after_accept", busy, 1);
    finish_op("t1", 0, 8'h14, 1'b0, 1'b0);

    launch(8'h82, 8'h4A);
    finish_op("t2", 0, 8'h38, 1'b1, 1'b0);

    launch(8'h7A, 8'hFF);
    finish_op("t3", 0, 8'h7B, 1'b0, 1'b1);

    // start pulsed on the 3rd busy cycle must be ignored
    dc0 = done_cnt;
    launch(8'h36, 8'h22);
    tick();
    tick();
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    tick();
    start = 1'b0;
    finish_op("ign", 3, 8'h14, 1'b0, 1'b0);
    repeat (12) tick();
    chk("ign_single_done", done_cnt - dc0, 1);
    chk("ign_idle", busy, 0);

    launch(8'h7F, 8'h80);
    finish_op("t4", 0, 8'hFF, 1'b1, 1'b1);

    // reset asserted on the 4th busy cycle aborts the operation
    dc0 = done_cnt;
    launch(8'h36, 8'h22);
    tick();
    tick();
    tick();
    chk("rab_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rab_busy", busy, 0);
    chk("rab_done", done, 0);
    chk("rab_diff", diff, 8'h00);
    chk("rab_flags", {overflow, borrow}, 2'b00);
    repeat (12) tick();
    chk("rab_no_done", done_cnt - dc0, 0);
    chk("rab_idle", busy, 0);

    launch(8'h36, 8'h22);
    finish_op("post_rst", 0, 8'h14, 1'b0, 1'b0);

    launch(8'h00, 8'h00);
    finish_op("zero", 0, 8'h00, 1'b0, 1'b0);

    // start held high: next accept at E(WIDTH+2); operand change mid-op has no effect
    start = 1'b1;
    a     = 8'h36;
    b     = 8'h22;
    tick();
    a     = 8'h55;
    b     = 8'h11;
    finish_op("thru1", 0, 8'h14, 1'b0, 1'b0);
    tick();
    chk("thru_reaccept_busy", busy, 1);
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    finish_op("thru2", 0, 8'h44, 1'b0, 1'b0);

    chk("busy_done_exclusive", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
